// File: rtl/pc_next_unit.sv
// Next-PC generator: prioritised redirects, stall buffering, sequential step.
// Optional target alignment trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_next_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      NSRC     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      STEP     = 4,
    parameter logic [WIDTH-1:0] TRAP_PC  = WIDTH'(32'h0000_0180)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*WIDTH-1:0] src_addr,
    output logic [WIDTH-1:0]      pc,
    output logic                  pc_valid,
    output logic                  redirect_pending,
    output logic [NSRC-1:0]       src_taken,
    output logic                  misalign
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend_addr;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_pc_d;
    logic [WIDTH-1:0] w_pend_addr_nxt;
    logic [WIDTH-1:0] w_tgt;
    logic [WIDTH-1:0] w_ld_addr;
    logic [NSRC-1:0]  r_pend_oh;
    logic [NSRC-1:0]  w_pend_oh_nxt;
    logic [NSRC-1:0]  w_oh;
    logic [NSRC-1:0]  r_taken;
    logic [NSRC-1:0]  w_taken_nxt;
    logic             w_any;
    logic             w_ld;
    logic             r_valid;
    logic             r_mis;
    logic             w_mis_nxt;

    // Scan downward so the lowest valid index is the last one written.
    always_comb begin
        w_any = |src_valid;
        w_oh  = '0;
        w_tgt = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                w_oh    = '0;
                w_oh[i] = 1'b1;
                w_tgt   = src_addr[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pend_addr_nxt = r_pend_addr;
        w_pend_oh_nxt   = r_pend_oh;
        w_taken_nxt     = '0;
        w_ld            = 1'b0;
        w_ld_addr       = w_tgt;
        w_pc_nxt        = r_pc;
        if (r_valid) begin
            unique case (r_state)
                RUN: begin
                    if (!stall) begin
                        if (w_any) begin
                            w_ld        = 1'b1;
                            w_taken_nxt = w_oh;
                        end else begin
                            w_pc_nxt = r_pc + WIDTH'(STEP);
                        end
                    end else if (w_any) begin
                        w_pend_addr_nxt = w_tgt;
                        w_pend_oh_nxt   = w_oh;
                        w_state_nxt     = HOLD;
                    end
                end
                HOLD: begin
                    if (stall) begin
                        if (w_any) begin
                            w_pend_addr_nxt = w_tgt;
                            w_pend_oh_nxt   = w_oh;
                        end
                    end else begin
                        w_ld        = 1'b1;
                        w_state_nxt = RUN;
                        if (w_any) begin
                            w_taken_nxt = w_oh;
                        end else begin
                            w_ld_addr   = r_pend_addr;
                            w_taken_nxt = r_pend_oh;
                        end
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_comb begin
        w_mis_nxt = 1'b0;
        w_pc_d    = w_pc_nxt;
        if (w_ld) begin
            if (w_ld_addr[1:0] != 2'b00) begin
                w_pc_d    = TRAP_PC;
                w_mis_nxt = 1'b1;
            end else begin
                w_pc_d = w_ld_addr;
            end
        end
    end
`else
    logic w_unused_trap;
    assign w_unused_trap = ^TRAP_PC;

    always_comb begin
        w_mis_nxt = 1'b0;
        w_pc_d    = w_ld ? w_ld_addr : w_pc_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_pc        <= RESET_PC;
            r_pend_addr <= '0;
            r_pend_oh   <= '0;
            r_taken     <= '0;
            r_valid     <= 1'b0;
            r_mis       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_d;
            r_pend_addr <= w_pend_addr_nxt;
            r_pend_oh   <= w_pend_oh_nxt;
            r_taken     <= w_taken_nxt;
            r_valid     <= 1'b1;
            r_mis       <= w_mis_nxt;
        end
    end

    assign pc               = r_pc;
    assign pc_valid         = r_valid;
    assign redirect_pending = (r_state == HOLD);
    assign src_taken        = r_taken;
    assign misalign         = r_mis;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed table, reset-in-HOLD sequence, random run.
// Expected values follow PC_ALIGN_CHECK_EN when the build defines it.
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [3:0]  src_valid;
    logic [31:0] addr [4];
    logic [127:0] src_addr;
    logic [31:0] pc;
    logic        pc_valid;
    logic        redirect_pending;
    logic [3:0]  src_taken;
    logic        misalign;

    logic        z_stall;
    logic [3:0]  z_valid;
    logic [31:0] z_addr;
    logic [7:0]  pc8;
    logic        v8;
    logic        p8;
    logic [3:0]  t8;
    logic        m8;

    int ntests = 0;
    int nfail  = 0;

    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_hold;
    logic [31:0] m_paddr;
    int          m_pidx;
    logic [3:0]  m_taken;
    logic        m_mis;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] E102 = 32'h180;
    localparam logic [31:0] E106 = 32'h184;
    localparam logic        EMIS = 1'b1;
`else
    localparam logic [31:0] E102 = 32'h102;
    localparam logic [31:0] E106 = 32'h106;
    localparam logic        EMIS = 1'b0;
`endif

    always_comb src_addr = {addr[3], addr[2], addr[1], addr[0]};

    pc_next_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .src_valid(src_valid), .src_addr(src_addr),
        .pc(pc), .pc_valid(pc_valid),
        .redirect_pending(redirect_pending),
        .src_taken(src_taken), .misalign(misalign)
    );

    pc_next_unit #(.WIDTH(8), .RESET_PC(8'hFC)) u8 (
        .clk(clk), .rst_n(rst_n), .stall(z_stall),
        .src_valid(z_valid), .src_addr(z_addr),
        .pc(pc8), .pc_valid(v8),
        .redirect_pending(p8),
        .src_taken(t8), .misalign(m8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [3:0]  v;
        logic [31:0] a0, a1, a2, a3;
        logic [31:0] pc;
        logic [3:0]  tk;
        logic        pend;
        logic        mis;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mload(input logic [31:0] a, input int idx);
        m_taken = 4'b0001 << idx;
        m_pc    = a;
        m_mis   = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) begin
            m_pc  = 32'h180;
            m_mis = 1'b1;
        end
`endif
    endtask

    task automatic mstep();
        int sel;
        sel = -1;
        for (int k = 3; k >= 0; k--) if (src_valid[k]) sel = k;
        if (!m_valid) begin
            m_valid = 1'b1;
            m_taken = '0;
            m_mis   = 1'b0;
        end else if (stall) begin
            m_taken = '0;
            m_mis   = 1'b0;
            if (sel >= 0) begin
                m_hold  = 1'b1;
                m_paddr = addr[sel];
                m_pidx  = sel;
            end
        end else begin
            if (sel >= 0) mload(addr[sel], sel);
            else if (m_hold) mload(m_paddr, m_pidx);
            else begin
                m_pc    = m_pc + 32'd4;
                m_taken = '0;
                m_mis   = 1'b0;
            end
            m_hold = 1'b0;
        end
    endtask

    task automatic check_model();
        chk("pc", pc, m_pc);
        chk("pc_valid", pc_valid, m_valid);
        chk("pending", redirect_pending, m_hold);
        chk("src_taken", src_taken, m_taken);
        chk("misalign", misalign, m_mis);
    endtask

    task automatic cyc();
        mstep();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_hold  = 1'b0;
        m_paddr = 32'h0;
        m_pidx  = 0;
        m_taken = '0;
        m_mis   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        stall     = 1'b0;
        src_valid = '0;
        for (int k = 0; k < 4; k++) addr[k] = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_model();
        rst_n = 1'b1;
    endtask

    initial begin
        z_stall = 1'b0;
        z_valid = '0;
        z_addr  = '0;

        tbl[0]  = '{1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h4, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h8, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'b0110, 32'h0, 32'h100, 32'h200, 32'h0,
                    32'h100, 4'b0010, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h300,
                    32'h100, 4'b0000, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 4'b0001, 32'h40, 32'h0, 32'h0, 32'h0,
                    32'h100, 4'b0000, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h40, 4'b0001, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h44, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b0001, 32'h102, 32'h0, 32'h0, 32'h0,
                    E102, 4'b0001, 1'b0, EMIS};
        tbl[9]  = '{1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0,
                    E106, 4'b0000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'b0001, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0,
                    32'hFFFF_FFFC, 4'b0001, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0, 4'b0000, 1'b0, 1'b0};

        do_reset();
        chk("rel_pc", pc, 32'h0);
        chk("rel_valid", pc_valid, 1'b0);
        for (int i = 0; i < 12; i++) begin
            stall     = tbl[i].stall;
            src_valid = tbl[i].v;
            addr[0]   = tbl[i].a0;
            addr[1]   = tbl[i].a1;
            addr[2]   = tbl[i].a2;
            addr[3]   = tbl[i].a3;
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("t%0d_valid", i), pc_valid, 1'b1);
            chk($sformatf("t%0d_taken", i), src_taken, tbl[i].tk);
            chk($sformatf("t%0d_pend", i), redirect_pending, tbl[i].pend);
            chk($sformatf("t%0d_mis", i), misalign, tbl[i].mis);
            if (i == 0) chk("w8_first", {24'h0, pc8}, 32'hFC);
            if (i == 1) chk("w8_wrap", {24'h0, pc8}, 32'h00);
        end

        do_reset();
        cyc();
        cyc();
        stall     = 1'b1;
        src_valid = 4'b1000;
        addr[3]   = 32'h300;
        cyc();
        src_valid = 4'b0000;
        cyc();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_pend", redirect_pending, 1'b0);
        chk("arst_valid", pc_valid, 1'b0);
        chk("arst_taken", src_taken, 4'b0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        stall     = 1'b0;
        src_valid = 4'b0001;
        addr[0]   = 32'h500;
        cyc();
        src_valid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            cyc();
            ntests++;
            if (pc == 32'h300) begin
                nfail++;
                $display("FAIL stale_pend: got %h required not 300", pc);
            end
        end

        do_reset();
        for (int n = 0; n < 800; n++) begin
            stall = ($urandom_range(0, 9) < 4);
            src_valid = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            for (int k = 0; k < 4; k++) begin
                addr[k] = $urandom;
                if ($urandom_range(0, 7) != 0) addr[k][1:0] = 2'b00;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
